pp_seq: RTL and testbench

Command sequencer and initiator for the `pp` arithmetic core. It accepts a valid/ready stream of operand pairs with opcodes and drives the core's `cmd`/`in1`/`in2` lines at one command per cycle. It captures the core's registered `out1` result and returns each result on a valid/ready result stream, buffered so that downstream backpressure never drops a result. It sits between the host-side column streamer and the `pp` core, on the initiator side of `pp_ifc`.

---
 rtl/pp_pkg.sv | 32 +++
 rtl/pp_seq_if.sv | 42 ++++
 rtl/pp_res_fifo.sv | 77 +++++++
 rtl/pp_seq.sv | 125 ++++++++++++
 tb/tb_pp_seq.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/pp_pkg.sv
// rtl/pp_pkg.sv - shared types for the pp core sequencer
package pp_pkg;

   localparam int NUM_SIZE = 32;

   typedef enum logic [3:0] {
      NOOP   = 4'b0000,
      FX_ADD = 4'b0001
   } op_e;

   typedef struct packed {
      logic [NUM_SIZE-1:0] data;
      logic                last;
      logic                err;
      logic                ovf;
   } res_t;

   // Per-beat bookkeeping that travels alongside the core pipeline
   typedef struct packed {
      logic is_add;
      logic last;
      logic err;
      logic ovf;
   } stg_t;

   function automatic logic add_ovf(input logic [NUM_SIZE-1:0] a, input logic [NUM_SIZE-1:0] b);
      logic [NUM_SIZE-1:0] s;
      s = a + b;
      return (a[NUM_SIZE-1] == b[NUM_SIZE-1]) && (s[NUM_SIZE-1] != a[NUM_SIZE-1]);
   endfunction

endpackage

// File: rtl/pp_seq_if.sv
// rtl/pp_seq_if.sv - operand stream, result stream and core command lines of the sequencer
interface pp_seq_if #(parameter int NUM_SIZE = pp_pkg::NUM_SIZE);

   logic                s_valid;
   logic                s_ready;
   logic [3:0]          s_op;
   logic [NUM_SIZE-1:0] s_a;
   logic [NUM_SIZE-1:0] s_b;
   logic                s_last;

   logic [3:0]          pp_cmd;
   logic [NUM_SIZE-1:0] pp_in1;
   logic [NUM_SIZE-1:0] pp_in2;
   logic                pp_out;
   logic [NUM_SIZE-1:0] pp_out1;

   logic                m_valid;
   logic                m_ready;
   logic [NUM_SIZE-1:0] m_data;
   logic                m_last;
   logic                m_err;
   logic                m_ovf;

   modport master (
      input  s_valid, s_op, s_a, s_b, s_last,
      output s_ready,
      output pp_cmd, pp_in1, pp_in2,
      input  pp_out, pp_out1,
      output m_valid, m_data, m_last, m_err, m_ovf,
      input  m_ready
   );

   modport slave (
      output s_valid, s_op, s_a, s_b, s_last,
      input  s_ready,
      input  pp_cmd, pp_in1, pp_in2,
      output pp_out, pp_out1,
      input  m_valid, m_data, m_last, m_err, m_ovf,
      output m_ready
   );

endinterface

// File: rtl/pp_res_fifo.sv
// rtl/pp_res_fifo.sv - result FIFO with a registered head entry
module pp_res_fifo
   import pp_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push_i,
   input  res_t                   push_data_i,
   input  logic                   pop_i,
   output res_t                   head_o,
   output logic                   valid_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   empty_o,
   output logic                   full_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_C  = (AW+1)'(1);

   res_t            mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   res_t            head_q, head_d;
   logic            valid_q;

   // Head is precomputed from next-state pointers so the outputs leave a flop
   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push_i);
      rd_ptr_d = rd_ptr_q + AW'(pop_i);
      count_d  = count_q;
      if (push_i && !pop_i) begin
         count_d = count_q + ONE_C;
      end else if (!push_i && pop_i) begin
         count_d = count_q - ONE_C;
      end
      if (count_d == '0) begin
         head_d = '0;
      end else if (push_i && (wr_ptr_q == rd_ptr_d)) begin
         head_d = push_data_i;
      end else begin
         head_d = mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         valid_q  <= (count_d != '0);
      end
   end

   assign head_o  = head_q;
   assign valid_o = valid_q;
   assign count_o = count_q;
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == FULL_C);

endmodule

// File: rtl/pp_seq.sv
// rtl/pp_seq.sv - command sequencer/initiator for the pp core; PP_SEQ_OVF_EN enables local overflow flagging
module pp_seq #(
   parameter int NUM_SIZE   = pp_pkg::NUM_SIZE,
   parameter int FIFO_DEPTH = 4
) (
   input  logic      clk,
   input  logic      reset,
   pp_seq_if.master  bus,
   input  logic      clear_sticky,
   output logic      busy,
   output logic      err_opcode,
   output logic      ovf_sticky
);

   import pp_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic ST_WAIT = 1'b0;
   localparam logic ST_RUN  = 1'b1;

   logic                state_q, state_d;
   logic                v1_q, v2_q;
   stg_t                s1_q, s1_d, s2_q;
   logic [3:0]          cmd_q;
   logic [NUM_SIZE-1:0] in1_q, in2_q;
   logic                err_q;
   logic                accept, acc_add, acc_noop, acc_ovf;
   logic [CW-1:0]       count, reserved;
   logic                fifo_empty, fifo_full, fifo_valid;
   logic                push, pop, dead;
   res_t                push_data, head;

   always_comb begin
      reserved  = count + {{(CW-1){1'b0}}, v1_q} + {{(CW-1){1'b0}}, v2_q};
      acc_add   = (bus.s_op == FX_ADD);
      acc_noop  = (bus.s_op == NOOP);
`ifdef PP_SEQ_OVF_EN
      acc_ovf   = acc_add && add_ovf(bus.s_a, bus.s_b);
`else
      acc_ovf   = 1'b0;
`endif
      s1_d      = '{is_add: acc_add, last: bus.s_last, err: !acc_add && !acc_noop, ovf: acc_ovf};
      // A beat whose core went away while it was in flight returns a poisoned zero
      dead      = s2_q.err || !bus.pp_out;
      push      = v2_q;
      push_data = '{data: (s2_q.is_add && !dead) ? bus.pp_out1 : '0,
                    last: s2_q.last, err: dead, ovf: s2_q.ovf && !dead};
      state_d   = bus.pp_out ? ST_RUN : ST_WAIT;
   end

   assign bus.s_ready = (state_q == ST_RUN) && !fifo_full && (reserved < DEPTH_C);
   assign accept      = bus.s_valid && bus.s_ready;
   assign pop         = fifo_valid && bus.m_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_WAIT;
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         s1_q    <= '0;
         s2_q    <= '0;
         cmd_q   <= NOOP;
         in1_q   <= '0;
         in2_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         v1_q    <= accept;
         v2_q    <= v1_q;
         if (accept) begin
            s1_q  <= s1_d;
            cmd_q <= acc_add ? FX_ADD : NOOP;
            in1_q <= bus.s_a;
            in2_q <= bus.s_b;
         end else begin
            cmd_q <= NOOP;
         end
         if (v1_q) begin
            s2_q <= '{is_add: s1_q.is_add, last: s1_q.last,
                      err: s1_q.err || !bus.pp_out, ovf: s1_q.ovf};
         end
         err_q <= (accept && s1_d.err) || (err_q && !clear_sticky);
      end
   end

`ifdef PP_SEQ_OVF_EN
   logic ovf_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= (push && push_data.ovf) || (ovf_q && !clear_sticky);
      end
   end
   assign ovf_sticky = ovf_q;
`else
   assign ovf_sticky = 1'b0;
`endif

   pp_res_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (pop),
      .head_o      (head),
      .valid_o     (fifo_valid),
      .count_o     (count),
      .empty_o     (fifo_empty),
      .full_o      (fifo_full)
   );

   assign bus.pp_cmd  = cmd_q;
   assign bus.pp_in1  = in1_q;
   assign bus.pp_in2  = in2_q;
   assign bus.m_valid = fifo_valid;
   assign bus.m_data  = head.data;
   assign bus.m_last  = head.last;
   assign bus.m_err   = head.err;
   assign bus.m_ovf   = head.ovf;
   assign busy        = v1_q || v2_q || !fifo_empty;
   assign err_opcode  = err_q;

endmodule

// File: tb/tb_pp_seq.sv
// tb/tb_pp_seq.sv - directed self-checking bench for pp_seq with a behavioural pp core
module tb_pp_seq;
   import pp_pkg::*;

`ifdef PP_SEQ_OVF_EN
   localparam logic EXP_OVF = 1'b1;
`else
   localparam logic EXP_OVF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clear_sticky = 1'b0;
   logic        busy, err_opcode, ovf_sticky;
   logic [31:0] core_q = 32'd0;
   int          n_cmp = 0;
   int          n_mis = 0;
   int          acc, seen;
   logic [31:0] got [$];

   pp_seq_if bus ();

   pp_seq #(.NUM_SIZE(32), .FIFO_DEPTH(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .clear_sticky (clear_sticky),
      .busy         (busy),
      .err_opcode   (err_opcode),
      .ovf_sticky   (ovf_sticky)
   );

   always #5 clk = ~clk;

   // Core model: registers the sum one edge after the command is presented
   always @(posedge clk) core_q <= (bus.pp_cmd == FX_ADD) ? bus.pp_in1 + bus.pp_in2 : 32'd0;
   assign bus.pp_out1 = core_q;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic stream(input int max_acc, input int budget, input logic [31:0] base, output int n);
      logic rdy;
      n = 0;
      bus.s_op   = FX_ADD;
      bus.s_last = 1'b0;
      for (int c = 0; c < budget && n < max_acc; c++) begin
         bus.s_valid = 1'b1;
         bus.s_a     = base + n;
         bus.s_b     = n;
         rdy         = bus.s_ready;
         step();
         if (rdy) n++;
      end
      bus.s_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.s_valid = 1'b0; bus.s_op = NOOP; bus.s_a = '0; bus.s_b = '0; bus.s_last = 1'b0;
      bus.pp_out = 1'b0; bus.m_ready = 1'b0;
      step();
      expect_eq("rst_s_ready", bus.s_ready, 0);
      expect_eq("rst_m_valid", bus.m_valid, 0);
      expect_eq("rst_m_data", bus.m_data, 0);
      expect_eq("rst_busy", busy, 0);
      expect_eq("rst_err_opcode", err_opcode, 0);
      expect_eq("rst_ovf_sticky", ovf_sticky, 0);
      expect_eq("rst_pp_cmd", bus.pp_cmd, 0);
      expect_eq("rst_pp_in1", bus.pp_in1, 0);
      reset = 1'b0;

      // core held in reset: nothing may be accepted or issued
      bus.s_valid = 1'b1; bus.s_op = FX_ADD; bus.s_a = 32'd9; bus.s_b = 32'd9;
      for (int i = 0; i < 3; i++) begin
         step();
         expect_eq("wait_s_ready", bus.s_ready, 0);
         expect_eq("wait_pp_cmd", bus.pp_cmd, 0);
      end
      bus.s_valid = 1'b0;
      bus.pp_out  = 1'b1;
      step();
      expect_eq("alive_s_ready", bus.s_ready, 1);

      // three FX_ADD beats, last flagged on the third
      bus.m_ready = 1'b1;
      bus.s_valid = 1'b1; bus.s_a = 32'd5; bus.s_b = 32'd7;
      step();
      expect_eq("add_pp_cmd", bus.pp_cmd, FX_ADD);
      expect_eq("add_pp_in1", bus.pp_in1, 5);
      expect_eq("add_lat1", bus.m_valid, 0);
      bus.s_a = 32'hFFFF_FFFD; bus.s_b = 32'd1;
      step();
      expect_eq("add_lat2", bus.m_valid, 0);
      bus.s_a = 32'h7FFF_FFFF; bus.s_b = 32'd1; bus.s_last = 1'b1;
      step();
      bus.s_valid = 1'b0; bus.s_last = 1'b0;
      expect_eq("add0_valid", bus.m_valid, 1);
      expect_eq("add0_data", bus.m_data, 32'd12);
      expect_eq("add0_last", bus.m_last, 0);
      step();
      expect_eq("add1_valid", bus.m_valid, 1);
      expect_eq("add1_data", bus.m_data, 32'hFFFF_FFFE);
      step();
      expect_eq("add2_valid", bus.m_valid, 1);
      expect_eq("add2_data", bus.m_data, 32'h8000_0000);
      expect_eq("add2_last", bus.m_last, 1);
      expect_eq("add2_ovf", bus.m_ovf, EXP_OVF);
      expect_eq("add2_ovf_sticky", ovf_sticky, EXP_OVF);
      step();
      expect_eq("add_done_valid", bus.m_valid, 0);
      expect_eq("add_done_busy", busy, 0);

      // illegal opcode
      bus.s_valid = 1'b1; bus.s_op = 4'b0111; bus.s_a = 32'd1; bus.s_b = 32'd2;
      step();
      bus.s_valid = 1'b0;
      expect_eq("ill_pp_cmd", bus.pp_cmd, NOOP);
      expect_eq("ill_err_opcode", err_opcode, 1);
      step();
      step();
      expect_eq("ill_valid", bus.m_valid, 1);
      expect_eq("ill_data", bus.m_data, 0);
      expect_eq("ill_err", bus.m_err, 1);
      clear_sticky = 1'b1;
      step();
      clear_sticky = 1'b0;
      expect_eq("clr_err_opcode", err_opcode, 0);
      expect_eq("clr_ovf_sticky", ovf_sticky, 0);

      // backpressure: reservation stops at FIFO_DEPTH beats
      bus.m_ready = 1'b0;
      stream(99, 10, 32'd100, acc);
      expect_eq("bp_accepted", acc, 4);
      expect_eq("bp_s_ready", bus.s_ready, 0);
      expect_eq("bp_hold_data", bus.m_data, 32'd100);
      bus.m_ready = 1'b1;
      got.delete();
      for (int i = 0; i < 8; i++) begin
         if (bus.m_valid) got.push_back(bus.m_data);
         step();
      end
      expect_eq("bp_drained", got.size(), 4);
      for (int i = 0; i < 4 && i < got.size(); i++)
         expect_eq($sformatf("bp_data%0d", i), got[i], 32'd100 + 32'(2 * i));
      expect_eq("bp_busy", busy, 0);

      // reset with two beats in flight and two buffered
      bus.m_ready = 1'b0;
      stream(4, 10, 32'd200, acc);
      expect_eq("rstmid_accepted", acc, 4);
      expect_eq("rstmid_pre_busy", busy, 1);
      reset = 1'b1;
      #1;
      expect_eq("rstmid_m_valid", bus.m_valid, 0);
      expect_eq("rstmid_busy", busy, 0);
      expect_eq("rstmid_s_ready", bus.s_ready, 0);
      step();
      reset = 1'b0;
      bus.m_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (bus.m_valid) seen++;
      end
      expect_eq("rstmid_no_stale", seen, 0);
      expect_eq("rstmid_s_ready_back", bus.s_ready, 1);

      // core drops while two beats are in flight
      stream(2, 6, 32'd300, acc);
      expect_eq("drop_accepted", acc, 2);
      bus.pp_out = 1'b0;
      step();
      expect_eq("drop0_valid", bus.m_valid, 1);
      expect_eq("drop0_data", bus.m_data, 0);
      expect_eq("drop0_err", bus.m_err, 1);
      expect_eq("drop_s_ready", bus.s_ready, 0);
      step();
      expect_eq("drop1_valid", bus.m_valid, 1);
      expect_eq("drop1_data", bus.m_data, 0);
      expect_eq("drop1_err", bus.m_err, 1);
      step();
      expect_eq("drop_done_valid", bus.m_valid, 0);
      expect_eq("drop_done_busy", busy, 0);
      expect_eq("drop_wait_s_ready", bus.s_ready, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
